// File: rtl/hd44780_pkg.sv
// Shared types and 48 MHz timing defaults for the HD44780 4-bit write path.
// Used by hd44780_nybble_writer and hd44780_delay_counter.
package hd44780_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP_HI = 3'd1,
        ST_EHI_HI   = 3'd2,
        ST_ELO_HI   = 3'd3,
        ST_SETUP_LO = 3'd4,
        ST_EHI_LO   = 3'd5,
        ST_ELO_LO   = 3'd6,
        ST_EXEC     = 3'd7
    } state_e;

    localparam int unsigned DEF_SETUP_CLKS     = 3;
    localparam int unsigned DEF_E_HIGH_CLKS    = 12;
    localparam int unsigned DEF_E_LOW_CLKS     = 12;
    localparam int unsigned DEF_EXEC_CLKS      = 2000;
    localparam int unsigned DEF_LONG_EXEC_CLKS = 80000;
    localparam int          DEF_TIMER_BITS     = 17;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    // Counter reload for a state of 'clks' cycles; zero behaves as one.
    function automatic int unsigned load_clks(input int unsigned clks);
        return (clks == 0) ? 0 : clks - 1;
    endfunction

    // Clear (0x01) and home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic [7:0] d);
        return (d == CMD_CLEAR) || (d[7:1] == CMD_HOME[7:1]);
    endfunction

endpackage

// File: rtl/hd44780_nybble_writer_if.sv
// Request/acknowledge bundle between the upstream sequencers and the
// nybble writer; master drives requests, slave reports busy/done.
interface hd44780_nybble_writer_if;

    logic [7:0] DAT_I;
    logic       rs_i;
    logic       nibble_only_i;
    logic       start_strobe;
    logic       busy;
    logic       done_strobe;

    modport master (
        output DAT_I,
        output rs_i,
        output nibble_only_i,
        output start_strobe,
        input  busy,
        input  done_strobe
    );

    modport slave (
        input  DAT_I,
        input  rs_i,
        input  nibble_only_i,
        input  start_strobe,
        output busy,
        output done_strobe
    );

endinterface

// File: rtl/hd44780_delay_counter.sv
// Loadable down-counter that parks at zero; expire_o flags a zero count.
// Reload happens on every state entry of the writer FSM.
module hd44780_delay_counter #(
    parameter int TIMER_BITS = 17
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic [TIMER_BITS-1:0] load_val_i,
    output logic                  expire_o
);

    logic [TIMER_BITS-1:0] cnt_q;
    logic [TIMER_BITS-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/hd44780_nybble_writer.sv
// HD44780 4-bit bus writer: byte -> hi/lo nibble E pulses, then exec wait.
// Define HD44780_LONG_EXEC_EN to stretch the wait after clear/home commands.
module hd44780_nybble_writer
    import hd44780_pkg::*;
#(
    parameter int unsigned SETUP_CLKS     = DEF_SETUP_CLKS,
    parameter int unsigned E_HIGH_CLKS    = DEF_E_HIGH_CLKS,
    parameter int unsigned E_LOW_CLKS     = DEF_E_LOW_CLKS,
    parameter int unsigned EXEC_CLKS      = DEF_EXEC_CLKS,
    parameter int unsigned LONG_EXEC_CLKS = DEF_LONG_EXEC_CLKS,
    parameter int          TIMER_BITS     = DEF_TIMER_BITS
) (
    input  logic                          CLK_I,
    input  logic                          RST_I,
    hd44780_nybble_writer_if.slave        wr,
    output logic                          lcd_rs,
    output logic                          lcd_e,
    output logic [3:0]                    lcd_data
);

`ifdef HD44780_LONG_EXEC_EN
    localparam bit LongEn = 1'b1;
`else
    localparam bit LongEn = 1'b0;
`endif

    localparam logic [TIMER_BITS-1:0] SetupLd =
        TIMER_BITS'(load_clks(SETUP_CLKS));
    localparam logic [TIMER_BITS-1:0] EHighLd =
        TIMER_BITS'(load_clks(E_HIGH_CLKS));
    localparam logic [TIMER_BITS-1:0] ELowLd =
        TIMER_BITS'(load_clks(E_LOW_CLKS));
    localparam logic [TIMER_BITS-1:0] ExecLd =
        TIMER_BITS'(load_clks(EXEC_CLKS));
    localparam logic [TIMER_BITS-1:0] LongLd =
        TIMER_BITS'(load_clks(LONG_EXEC_CLKS));

    state_e     state_q, state_d;
    logic [7:0] dat_q, dat_d;
    logic       rs_q, rs_d;
    logic       nib_q, nib_d;
    logic       lcd_rs_q, lcd_rs_d;
    logic [3:0] lcd_data_q, lcd_data_d;
    logic       lcd_e_q, lcd_e_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic                  ld;
    logic [TIMER_BITS-1:0] ld_val;
    logic                  expire;
    logic                  long_sel;

    hd44780_delay_counter #(
        .TIMER_BITS (TIMER_BITS)
    ) u_delay (
        .clk_i      (CLK_I),
        .rst_ni     (RST_I),
        .load_i     (ld),
        .load_val_i (ld_val),
        .expire_o   (expire)
    );

    assign long_sel = LongEn && !rs_q && !nib_q && is_long_cmd(dat_q);

    always_comb begin
        state_d = state_q;
        dat_d   = dat_q;
        rs_d    = rs_q;
        nib_d   = nib_q;
        unique case (state_q)
            ST_IDLE: begin
                if (wr.start_strobe) begin
                    dat_d   = wr.DAT_I;
                    rs_d    = wr.rs_i;
                    nib_d   = wr.nibble_only_i;
                    state_d = wr.nibble_only_i ? ST_SETUP_LO
                                               : ST_SETUP_HI;
                end
            end
            ST_SETUP_HI: if (expire) state_d = ST_EHI_HI;
            ST_EHI_HI:   if (expire) state_d = ST_ELO_HI;
            ST_ELO_HI:   if (expire) state_d = ST_SETUP_LO;
            ST_SETUP_LO: if (expire) state_d = ST_EHI_LO;
            ST_EHI_LO:   if (expire) state_d = ST_ELO_LO;
            ST_ELO_LO:   if (expire) state_d = ST_EXEC;
            ST_EXEC:     if (expire) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Pin values change only on entry to a SETUP state; they are
    // otherwise frozen through the E pulse, hold and exec wait.
    always_comb begin
        lcd_rs_d   = lcd_rs_q;
        lcd_data_d = lcd_data_q;
        if (state_d != state_q) begin
            if (state_d == ST_SETUP_HI) begin
                lcd_rs_d   = rs_d;
                lcd_data_d = dat_d[7:4];
            end else if (state_d == ST_SETUP_LO) begin
                lcd_rs_d   = rs_d;
                lcd_data_d = dat_d[3:0];
            end
        end
        lcd_e_d = (state_d == ST_EHI_HI) || (state_d == ST_EHI_LO);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_q == ST_EXEC) && (state_d == ST_IDLE);
    end

    always_comb begin
        ld     = (state_d != state_q);
        ld_val = '0;
        unique case (state_d)
            ST_SETUP_HI, ST_SETUP_LO: ld_val = SetupLd;
            ST_EHI_HI,   ST_EHI_LO:   ld_val = EHighLd;
            ST_ELO_HI,   ST_ELO_LO:   ld_val = ELowLd;
            ST_EXEC:     ld_val = long_sel ? LongLd : ExecLd;
            default:     ld_val = '0;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q    <= ST_IDLE;
            dat_q      <= '0;
            rs_q       <= 1'b0;
            nib_q      <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= '0;
            lcd_e_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dat_q      <= dat_d;
            rs_q       <= rs_d;
            nib_q      <= nib_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_data_q <= lcd_data_d;
            lcd_e_q    <= lcd_e_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign lcd_rs         = lcd_rs_q;
    assign lcd_e          = lcd_e_q;
    assign lcd_data       = lcd_data_q;
    assign wr.busy        = busy_q;
    assign wr.done_strobe = done_q;

endmodule

// File: tb/tb_hd44780_nybble_writer.sv
// Scoreboard bench for hd44780_nybble_writer: expected E pulses and done
// cycles are queued at request time and matched by a pin monitor.
module tb_hd44780_nybble_writer;

    typedef struct {
        logic       rs;
        logic [3:0] d;
        int         cyc;
    } pulse_t;

    logic       clk;
    logic       RST_I;
    logic       lcd_rs;
    logic       lcd_e;
    logic [3:0] lcd_data;

    hd44780_nybble_writer_if bus ();

    hd44780_nybble_writer dut (
        .CLK_I    (clk),
        .RST_I    (RST_I),
        .wr       (bus),
        .lcd_rs   (lcd_rs),
        .lcd_e    (lcd_e),
        .lcd_data (lcd_data)
    );

    int     checks   = 0;
    int     failures = 0;
    int     cyc      = 0;
    int     rises    = 0;
    pulse_t pq[$];
    int     dq[$];

    pulse_t cur;
    logic   prev_e   = 1'b0;
    int     rise_cyc = 0;
    int     hold_cyc = -1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pin monitor: every E rise must match the head of the pulse queue,
    // every done_strobe the head of the done queue.
    always @(negedge clk) begin
        if (!RST_I) begin
            prev_e   = 1'b0;
            hold_cyc = -1;
        end else begin
            if (lcd_e && !prev_e) begin
                rises++;
                if (pq.size() == 0) begin
                    chk("e_unexp", 32'(lcd_e), 32'd0);
                end else begin
                    cur = pq.pop_front();
                    chk("e_rise_cyc", cyc, cur.cyc);
                    chk("e_data", 32'(lcd_data), 32'(cur.d));
                    chk("e_rs", 32'(lcd_rs), 32'(cur.rs));
                    rise_cyc = cyc;
                end
            end
            if (!lcd_e && prev_e) begin
                chk("e_width", cyc - rise_cyc, 32'd12);
                hold_cyc = cyc + 11;
            end
            if (cyc == hold_cyc) begin
                chk("e_hold_data", 32'(lcd_data), 32'(cur.d));
                chk("e_hold_rs", 32'(lcd_rs), 32'(cur.rs));
            end
            if (bus.done_strobe) begin
                if (dq.size() == 0) begin
                    chk("done_unexp", 32'(bus.done_strobe), 32'd0);
                end else begin
                    chk("done_cyc", cyc, dq.pop_front());
                    chk("done_busy", 32'(bus.busy), 32'd0);
                end
            end
            prev_e = lcd_e;
        end
    end

    // Called at a negedge; the strobe is sampled on the next posedge,
    // which makes the current cyc value "cycle 0" of the write.
    task automatic wr(input logic [7:0] d, input logic r, input logic n);
        int     c0;
        int     x;
        pulse_t p;
        c0 = cyc;
        x  = 2000;
`ifdef HD44780_LONG_EXEC_EN
        if (!r && !n && (d == 8'h01 || d == 8'h02 || d == 8'h03))
            x = 80000;
`endif
        if (!n) begin
            p.rs  = r;
            p.d   = d[7:4];
            p.cyc = c0 + 4;
            pq.push_back(p);
        end
        p.rs  = r;
        p.d   = d[3:0];
        p.cyc = c0 + (n ? 4 : 31);
        pq.push_back(p);
        dq.push_back(c0 + (n ? 27 : 54) + x + 1);
        bus.DAT_I         = d;
        bus.rs_i          = r;
        bus.nibble_only_i = n;
        bus.start_strobe  = 1'b1;
        @(negedge clk);
        bus.start_strobe  = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((dq.size() != 0 || pq.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk({tag, "_done_q"}, dq.size(), 32'd0);
        chk({tag, "_pulse_q"}, pq.size(), 32'd0);
    endtask

    initial begin
        int c0;
        int c1;
        int r0;
        int act;
        bus.DAT_I         = '0;
        bus.rs_i          = 1'b0;
        bus.nibble_only_i = 1'b0;
        bus.start_strobe  = 1'b0;
        RST_I             = 1'b1;
        #2 RST_I = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_e", 32'(lcd_e), 32'd0);
        chk("rst_rs", 32'(lcd_rs), 32'd0);
        chk("rst_data", 32'(lcd_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done_strobe), 32'd0);
        RST_I = 1'b1;

        act = 0;
        repeat (100) begin
            @(negedge clk);
            act += int'(lcd_e | bus.busy | bus.done_strobe);
        end
        chk("idle_activity", act, 32'd0);

        // Byte write, ignored strobe while busy, back-to-back write.
        c0 = cyc;
        wr(8'hA5, 1'b1, 1'b0);
        chk("busy_c1", 32'(bus.busy), 32'd1);
        wait_until(c0 + 100);
        bus.DAT_I        = 8'hFF;
        bus.rs_i         = 1'b0;
        bus.start_strobe = 1'b1;
        @(negedge clk);
        bus.start_strobe = 1'b0;
        chk("ign_data", 32'(lcd_data), 32'h5);
        chk("ign_rs", 32'(lcd_rs), 32'd1);
        chk("ign_busy", 32'(bus.busy), 32'd1);
        wait_until(c0 + 2055);
        chk("bb_done", 32'(bus.done_strobe), 32'd1);
        chk("bb_busy", 32'(bus.busy), 32'd0);
        c1 = cyc;
        wr(8'h41, 1'b1, 1'b0);
        chk("bb_busy2", 32'(bus.busy), 32'd1);
        wait_until(c1 + 2057);
        chk("bb_done_q", dq.size(), 32'd0);
        chk("bb_pulse_q", pq.size(), 32'd0);

        // Nibble-only init write: a single E pulse.
        r0 = rises;
        wr(8'h03, 1'b0, 1'b1);
        wait_drain("nib", 3000);
        chk("nib_pulses", rises - r0, 32'd1);

        // Reset in the middle of the high-nibble E pulse.
        c0 = cyc;
        wr(8'h5A, 1'b1, 1'b0);
        wait_until(c0 + 6);
        chk("pre_rst_e", 32'(lcd_e), 32'd1);
        #1 RST_I = 1'b0;
        #1;
        chk("mid_rst_e", 32'(lcd_e), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        pq.delete();
        dq.delete();
        repeat (3) @(negedge clk);
        RST_I = 1'b1;
        @(negedge clk);
        wr(8'h28, 1'b0, 1'b0);
        wait_drain("post_rst", 3000);

        // Clear command as instruction and as data.
        wr(8'h01, 1'b0, 1'b0);
        wait_drain("clr_cmd", 90000);
        wr(8'h01, 1'b1, 1'b0);
        wait_drain("clr_data", 3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hd44780_nybble_writer.md
Name: hd44780_nybble_writer

Overview:
Bus-timing stage directly upstream of the HD44780 LCD pins in the top level. It accepts one command or data byte via a start strobe, splits it into high then low nibbles, and drives lcd_rs, lcd_data[3:0] and lcd_e with HD44780 4-bit write timing (R/~W tied low). After the write it holds busy for the controller execution time, then pulses done. The init sequencer and text controller sit upstream; a nibble-only mode serves the 4-bit init sequence (0x3, 0x3, 0x3, 0x2).

Parameters:
SETUP_CLKS, 3, clocks lcd_rs/lcd_data are stable before lcd_e rises (62.5 ns at 48 MHz, tAS >= 40 ns)
E_HIGH_CLKS, 12, clocks lcd_e held high (250 ns, PW_EH >= 230 ns)
E_LOW_CLKS, 12, clocks lcd_e low after fall with data held (tH, cycle >= 500 ns)
EXEC_CLKS, 2000, post-write execution wait (41.7 us >= 37 us)
LONG_EXEC_CLKS, 80000, clear/home execution wait (1.67 ms >= 1.52 ms); used only with the optional feature
TIMER_BITS, 17, delay counter width; must hold max(all *_CLKS)

Ports:
CLK_I  in  1  system clock (48 MHz HFOSC)
RST_I  in  1  asynchronous, active-low reset
DAT_I  in  8  byte to write; in nibble-only mode only DAT_I[3:0] is used
rs_i  in  1  register select for this write (0 = command, 1 = data)
nibble_only_i  in  1  1 = write DAT_I[3:0] as a single nibble
start_strobe  in  1  one-cycle request; sampled with DAT_I/rs_i/nibble_only_i
busy  out  1  high from accept until done_strobe
done_strobe  out  1  one-cycle pulse when write and exec wait are complete
lcd_rs  out  1  to LCD RS pin
lcd_e  out  1  to LCD E pin
lcd_data  out  4  to LCD DB7..DB4

Behaviour:
- All outputs are registered. On RST_I low, asynchronously clear state to IDLE, counter to 0, and every output to 0. Reset mid-write drops lcd_e immediately. No partial nibble is resumed.
- Accept: start_strobe high while state == IDLE (busy == 0). Latch DAT_I, rs_i and nibble_only_i. Ignore start_strobe while busy (no queue, no error).
- Accept is cycle 0. busy rises at cycle 1.
- States: IDLE -> SETUP_HI -> EHI_HI -> ELO_HI -> SETUP_LO -> EHI_LO -> ELO_LO -> EXEC -> IDLE.
- nibble_only skips SETUP_HI/EHI_HI/ELO_HI and enters SETUP_LO carrying DAT_I[3:0].
- Each timed state lasts exactly its *_CLKS cycles. A parameter value of 0 is treated as 1.
- SETUP_x: lcd_rs = latched rs, lcd_data = nibble (hi = [7:4], lo = [3:0]), lcd_e = 0.
- EHI_x: lcd_e = 1, with rs and data unchanged.
- ELO_x: lcd_e = 0, with rs and data still unchanged.
- EXEC: lcd_e = 0. lcd_rs and lcd_data keep their last values.
- Latency, with S = SETUP_CLKS, H = E_HIGH_CLKS, L = E_LOW_CLKS, X = exec wait:
  - byte: done_strobe at cycle 2(S+H+L)+X+1 (2055 with defaults)
  - nibble-only: done_strobe at cycle (S+H+L)+X+1 (2028 with defaults)
- done_strobe is high for one cycle, the first cycle back in IDLE, with busy = 0. A start_strobe in that same cycle is accepted (back-to-back writes).
- Counter: a down-counter of TIMER_BITS bits, loaded on each state entry with (CLKS-1). It advances state when the count is 0. It never wraps.
- lcd_e rises only after at least S cycles of stable rs/data, and data never changes while lcd_e is high or in the following L cycles.

Optional Feature:
HD44780_LONG_EXEC_EN
- Defined: when latched rs == 0, nibble_only == 0, and the byte is 0x01 (clear) or 0x02/0x03 (home), the EXEC state loads LONG_EXEC_CLKS; all other writes use EXEC_CLKS.
- Undefined: EXEC_CLKS always. LONG_EXEC_CLKS is unused, and the upstream block must insert its own delay after clear/home.

Decomposition:
- Package hd44780_pkg holds:
  - the state encoding constants
  - default timing constants for 48 MHz
  - command codes CMD_CLEAR = 8'h01, CMD_HOME = 8'h02
- One sub-module is natural: hd44780_delay_counter (load value + load strobe in, expire strobe out, TIMER_BITS wide), instantiated once.

Test Plan:
- Reset then idle: hold RST_I low 5 cycles and release -> all outputs 0, busy 0, no lcd_e activity for 100 cycles.
- Byte write: DAT_I = 8'hA5, rs_i = 1, strobe at t0 -> lcd_data = 4'hA with lcd_e high cycles 4..15; lcd_data = 4'h5 with lcd_e high cycles 31..42; lcd_rs = 1 throughout; done_strobe at cycle 2055.
- Nibble-only: DAT_I = 8'h03, rs_i = 0, nibble_only_i = 1 -> exactly one lcd_e pulse with lcd_data = 4'h3; done_strobe at cycle 2028.
- Busy drop and back-to-back: strobe again at cycle 100 (ignored, lcd_data unchanged); strobe in the done_strobe cycle with 8'h41 -> accepted, second byte written with no gap.
- Reset mid-pulse: assert RST_I during EHI_HI -> lcd_e goes 0 within the same cycle (async), busy 0, next write behaves normally.
- HD44780_LONG_EXEC_EN: write 8'h01, rs_i = 0 -> done_strobe at cycle 80055; write 8'h01, rs_i = 1 -> cycle 2055; with the macro undefined, both -> 2055.
